// File: rtl/vga_sync_monitor.sv
// -----------------------------------------------------------------------------
// vga_sync_monitor
//   Receive-side checker for a VGA source. Samples HS/VS/rgb on the pixel
//   clock, recovers the pixel coordinates, checks line and frame timing and
//   reports lock. It also captures the pixel at one probe coordinate.
//
//   Timing reference: a line starts at the HS assert edge (sync, back porch,
//   active, front porch). A frame starts on the line whose HS edge coincides
//   with, or follows, the VS assert edge.
//
// Ports
//   clk         in   pixel clock
//   reset       in   asynchronous, active-high
//   HS, VS      in   sync inputs, asserted level = SYNC_POL
//   rgb         in   8-bit pixel data
//   probe_x/y   in   probe coordinate, sampled every cycle
//   locked      out  timing locked (state == LOCKED)
//   pix_valid   out  pix_x/pix_y/pix_rgb describe a visible pixel
//   pix_x/y     out  recovered coordinate, held while pix_valid = 0
//   pix_rgb     out  recovered pixel data, held while pix_valid = 0
//   probe_rgb   out  last captured probe pixel
//   probe_valid out  one-cycle pulse when probe_rgb is loaded
//   line_err    out  one-cycle pulse: bad line length or HS width
//   frame_err   out  one-cycle pulse: bad line count or VS width
//   frame_count out  locked-frame counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module vga_sync_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       HS,
    input  logic       VS,
    input  logic [7:0] rgb,
    input  logic [9:0] probe_x,
    input  logic [9:0] probe_y,
    output logic       locked,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [7:0] pix_rgb,
    output logic [7:0] probe_rgb,
    output logic       probe_valid,
    output logic       line_err,
    output logic       frame_err,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic       C_POL     = 1'(SYNC_POL);
    localparam logic [9:0] C_CNT_MAX = 10'h3FF;
    localparam logic [9:0] C_H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_HS_LAST = 10'(H_SYNC - 1);
    localparam logic [9:0] C_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_VS_END  = 10'(V_SYNC);
    localparam logic [9:0] C_H_MIN   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] C_H_MAX   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] C_V_MIN   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] C_V_MAX   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_acq_err;   // an error was seen in the frame being acquired
    logic       r_hs1, r_vs1, r_hs2, r_vs2;
    logic [7:0] r_rgb1;
    logic [9:0] r_h_cnt, r_v_cnt;
    logic       r_vs_pend;   // VS asserted earlier in this line, frame starts at next HS edge
    logic       r_h_seen;    // h_cnt has been aligned by an HS edge, line checks are meaningful

    logic       w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
    logic [9:0] w_h_nxt, w_v_nxt;
    logic       w_line_err, w_frame_err, w_err, w_to_search, w_visible;

    assign w_hs_rise = (r_hs1 == C_POL) && (r_hs2 != C_POL);
    assign w_hs_fall = (r_hs1 != C_POL) && (r_hs2 == C_POL);
    assign w_vs_rise = (r_vs1 == C_POL) && (r_vs2 != C_POL);
    assign w_vs_fall = (r_vs1 != C_POL) && (r_vs2 == C_POL);

    // w_h_nxt / w_v_nxt are the coordinates of the pixel now held in stage 1,
    // which keeps pix_* two cycles behind the pins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_h_nxt = r_h_cnt;
        w_v_nxt = r_v_cnt;
        if (w_hs_rise) begin
            w_h_nxt = '0;
            if (w_vs_rise || r_vs_pend) begin
                w_v_nxt = '0;
            end else if (r_v_cnt != C_CNT_MAX) begin
                w_v_nxt = r_v_cnt + 10'd1;
            end
        end else if (r_h_cnt != C_CNT_MAX) begin
            w_h_nxt = r_h_cnt + 10'd1;
        end
    end

    assign w_line_err = r_h_seen &&
                        ((w_hs_rise && (r_h_cnt != C_H_LAST)) ||
                         (w_hs_fall && (r_h_cnt != C_HS_LAST)));

    // VS deassert normally coincides with the HS edge that opens line V_SYNC,
    // so it is judged against the line number that edge produces.
    assign w_frame_err = (r_state != ST_SEARCH) &&
                         ((w_vs_rise && (r_v_cnt != C_V_LAST)) ||
                          (w_vs_fall && (w_v_nxt != C_VS_END)));

    assign w_err       = w_line_err || w_frame_err;
    assign w_to_search = (r_state == ST_LOCKED) && w_err;
    assign w_visible   = (w_h_nxt >= C_H_MIN) && (w_h_nxt <= C_H_MAX) &&
                         (w_v_nxt >= C_V_MIN) && (w_v_nxt <= C_V_MAX);

    // Sampling, counters, pixel recovery and probe capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Sync history resets to the idle level so a source that is
            // already idle does not produce a phantom edge.
            r_hs1       <= ~C_POL;
            r_vs1       <= ~C_POL;
            r_hs2       <= ~C_POL;
            r_vs2       <= ~C_POL;
            r_rgb1      <= '0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_vs_pend   <= 1'b0;
            r_h_seen    <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the values from before this edge.
            r_hs1     <= HS;
            r_vs1     <= VS;
            r_hs2     <= r_hs1;
            r_vs2     <= r_vs1;
            r_rgb1    <= rgb;
            r_h_cnt   <= w_h_nxt;
            r_v_cnt   <= w_v_nxt;
            r_vs_pend <= w_hs_rise ? 1'b0 : (w_vs_rise || r_vs_pend);
            r_h_seen  <= w_to_search ? 1'b0 : (w_hs_rise || r_h_seen);
            line_err  <= w_line_err;
            frame_err <= w_frame_err;

            pix_valid <= w_visible && (r_state == ST_LOCKED);
            if (w_visible && (r_state == ST_LOCKED)) begin
                pix_x   <= w_h_nxt - C_H_MIN;
                pix_y   <= w_v_nxt - C_V_MIN;
                pix_rgb <= r_rgb1;
            end

            probe_valid <= 1'b0;
            if (pix_valid && (pix_x == probe_x) && (pix_y == probe_y)) begin
                probe_rgb   <= pix_rgb;
                probe_valid <= 1'b1;
            end
        end
    end

    // Lock FSM with registered locked/frame_count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SEARCH;
            r_acq_err   <= 1'b0;
            locked      <= 1'b0;
            frame_count <= '0;
        end else begin
            unique case (r_state)
                ST_SEARCH: begin
                    if (w_vs_rise) begin
                        r_state   <= ST_ACQUIRE;
                        r_acq_err <= 1'b0;
                    end
                end
                ST_ACQUIRE: begin
                    if (w_vs_rise) begin
                        // The frame closing at this edge must be clean,
                        // including any error detected at the edge itself.
                        if (!r_acq_err && !w_err) begin
                            r_state <= ST_LOCKED;
                            locked  <= 1'b1;
                        end
                        r_acq_err <= 1'b0;
                    end else if (w_err) begin
                        r_acq_err <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_err) begin
                        r_state     <= ST_SEARCH;
                        locked      <= 1'b0;
                        frame_count <= '0;
                    end else if (w_vs_rise) begin
                        frame_count <= frame_count + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_SEARCH;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule
